// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFETCH_PERF_EN (adds perf_fetched / perf_stalls).
package ifetch_pkg;
  localparam int WORD_BYTES = 4;
  localparam int PC_W       = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

  // One queued fetch result: the word and the byte address it came from.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying the head instruction and its PC.
interface instruction_fetch_if #(parameter int ADDR_W = 32);
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (output out_valid, out_instr, out_pc, input  out_ready);
  modport slave  (input  out_valid, out_instr, out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries. Synchronous flush wins over push and pop.
// Push while full is accepted when a pop happens in the same cycle.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  fetch_entry_t   r_mem [DEPTH];
  logic           w_do_push, w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                 (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and storage update; flush only rewinds pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, fetch-limit compare, redirect handling and queue to decode.
// Optional feature macro: IFETCH_PERF_EN adds saturating pop/stall counters.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                IMEM_WORDS  = 17,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [31:0]         imem_instr,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  instruction_fetch_if.master out_if,
  output logic                done
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stalls
`endif
);
  // One bit wider than the PC so the limit for a full address space still fits.
  localparam logic [ADDR_W:0]   FETCH_LIMIT = (ADDR_W+1)'(IMEM_WORDS * WORD_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(WORD_BYTES);

  logic [ADDR_W-1:0] r_pc;
  logic              w_done_fetch, w_push, w_pop, w_full, w_empty;
  fetch_entry_t      w_push_data, w_head;
  logic              w_unused_ok;

  assign imem_addr    = r_pc;
  assign w_done_fetch = ({1'b0, r_pc} >= FETCH_LIMIT);
  assign w_pop        = out_if.out_valid && out_if.out_ready;
  assign w_push       = !w_done_fetch && !redirect_valid && (!w_full || w_pop);
  assign w_push_data  = '{pc: PC_W'(r_pc), instr: imem_instr};

  // Low target bits are dropped: fetch is always word aligned.
  assign w_unused_ok  = ^redirect_pc[1:0];

  // PC: redirect first, otherwise advance on each accepted push (wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
    else if (redirect_valid) r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (w_push)         r_pc <= r_pc + PC_STEP;
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Outputs read zero while empty so stale storage never leaks to decode.
  assign out_if.out_valid = !w_empty;
  assign out_if.out_instr = w_empty ? '0 : w_head.instr;
  assign out_if.out_pc    = w_empty ? '0 : w_head.pc[ADDR_W-1:0];
  assign done             = w_done_fetch && w_empty;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stalls;

  // Saturating handshake and backpressure counters; untouched by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 1'b1;
      if (out_if.out_valid && !out_if.out_ready && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalls  = r_perf_stalls;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: straight-line fetch, limit/restart,
// backpressure, redirect, misaligned redirect and mid-run reset.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls;
`endif
  int          n_chk = 0;
  int          n_err = 0;

  instruction_fetch_if #(.ADDR_W(32)) oif ();

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_WORDS(17), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (oif.master),
    .done           (done)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: 17 distinct words, garbage beyond the program.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd68) ? (32'h1000_0013 ^ (a << 12)) : 32'hDEAD_BEEF;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; oif.out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_valid", 32'(oif.out_valid), 32'd0);
    chk("rst_pc",    oif.out_pc,    32'd0);
    chk("rst_instr", oif.out_instr, 32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_addr",  imem_addr,     32'd0);
    step();
    rst_n = 1'b1; oif.out_ready = 1'b1;

    // Straight-line fetch: one word per cycle from 0 to 64
    for (int i = 0; i < 17; i++) begin
      step();
      chk("sl_valid", 32'(oif.out_valid), 32'd1);
      chk("sl_pc",    oif.out_pc, 32'(4*i));
      chk("sl_instr", oif.out_instr, mem_word(32'(4*i)));
      chk("sl_done",  32'(done), 32'd0);
    end
    step();
    chk("lim_valid", 32'(oif.out_valid), 32'd0);
    chk("lim_done",  32'(done), 32'd1);
    chk("lim_addr",  imem_addr, 32'd68);

    // Restart from done with a redirect to 0x18
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    step();
    redirect_valid = 1'b0;
    chk("rs_done",  32'(done), 32'd0);
    chk("rs_valid", 32'(oif.out_valid), 32'd0);
    chk("rs_addr",  imem_addr, 32'h18);
    step();
    chk("rs_pc",    oif.out_pc, 32'h18);
    chk("rs_instr", oif.out_instr, mem_word(32'h18));

    // Backpressure: head holds PC 0, PC stops at 8
    rst_n = 1'b0; oif.out_ready = 1'b0;
    #1;
    chk("bp_rst_valid", 32'(oif.out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("bp_first_pc", oif.out_pc, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_pc",    oif.out_pc, 32'd0);
      chk("bp_hold_instr", oif.out_instr, mem_word(32'd0));
      chk("bp_addr",       imem_addr, 32'd8);
    end
`ifdef IFETCH_PERF_EN
    chk("bp_stalls", perf_stalls, 32'd5);
`endif
    oif.out_ready = 1'b1;
    step();
    chk("bp_pc4", oif.out_pc, 32'd4);
    step();
    chk("bp_pc8", oif.out_pc, 32'd8);
`ifdef IFETCH_PERF_EN
    chk("bp_fetched", perf_fetched, 32'd2);
`endif

    // Redirect to 0x0C while queue holds 0x10 and 0x14
    step();
    chk("rd_pre_pc", oif.out_pc, 32'h0C);
    step();
    chk("rd_head", oif.out_pc, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0C;
    step();
    redirect_valid = 1'b0;
    chk("rd_bubble", 32'(oif.out_valid), 32'd0);
    chk("rd_addr",   imem_addr, 32'h0C);
    step();
    chk("rd_pc",    oif.out_pc, 32'h0C);
    chk("rd_instr", oif.out_instr, mem_word(32'h0C));
    step();
    chk("rd_next", oif.out_pc, 32'h10);

    // Misaligned redirect lands on the containing word
    redirect_valid = 1'b1; redirect_pc = 32'h0E;
    step();
    redirect_valid = 1'b0;
    chk("ma_bubble", 32'(oif.out_valid), 32'd0);
    step();
    chk("ma_pc", oif.out_pc, 32'h0C);

    // Mid-run reset with a full queue
    oif.out_ready = 1'b0;
    step();
    step();
    chk("mr_addr_full", imem_addr, 32'h14);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(oif.out_valid), 32'd0);
    chk("mr_addr",  imem_addr, 32'd0);
    step();
    rst_n = 1'b1; oif.out_ready = 1'b1;
    step();
    chk("mr_first_valid", 32'(oif.out_valid), 32'd1);
    chk("mr_first_pc",    oif.out_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that drives the address side of the processor's instruction memory and delivers fetched words to decode. Holds the PC, issues one byte address per cycle to the combinational-read instruction memory, captures the returned word into a small queue, and presents it with its PC through a valid/ready handshake. Branch and jump redirects from execute flush the queue and reload the PC. The unit stops fetching when the PC runs past the end of the loaded program.

## Interface

- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 0: byte address loaded into the PC at reset.
- `IMEM_WORDS`, 17: number of valid instruction words; the fetch limit is `IMEM_WORDS*4`.
- `QUEUE_DEPTH`, 2: fetch queue entries, power of two, at least 2.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; asynchronous active-low reset.
- `imem_addr`  out  ADDR_W  byte address to instruction memory; always equals the PC.
- `imem_instr`  in  32  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  ADDR_W  redirect target byte address.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  ADDR_W  byte address of the head instruction.
- `done`  out  1  PC is at or beyond the fetch limit and the queue is empty.

## Operation

- The PC register resets to `RESET_PC` with bits [1:0] forced to 0. `imem_addr` = PC.
- Push: when `done_fetch` (PC >= `IMEM_WORDS*4`) is 0, there is no redirect, and the queue is not full or is popping this cycle, push {PC, `imem_instr`} and set PC to PC+4.
- Pop: when `out_valid` and `out_ready` are both 1, remove the head. Push and pop may happen in the same cycle, including when the queue is full, which gives one instruction per cycle.
- Redirect has priority over everything. The queue is flushed, any same-cycle pop is discarded, there is no push that cycle, and PC becomes {redirect_pc[ADDR_W-1:2], 2'b00}.
- At the fetch limit, pushes stop. `done` is 1 once the queue drains. A redirect to an in-range address clears `done` on the next cycle.
- PC+4 wraps modulo 2^ADDR_W. A wrapped PC is below the limit and fetches normally.
- Out-of-range `imem_instr` contents are never captured, because no push happens at the limit.

## Timing

- Reset values: PC = `RESET_PC`, queue empty, `out_valid`=0, `out_instr`=0, `out_pc`=0, `done`=0. If `IMEM_WORDS`=0, `done` is 1 in the first cycle after reset.
- Fetch-to-output latency is 1 cycle. A word pushed at edge N is visible on `out_*` after edge N.
- After reset release, the first `out_valid`=1 appears after the first rising edge.
- Redirect penalty: `redirect_valid` is high in cycle N, `out_valid`=0 in cycle N+1, and the target instruction is valid in cycle N+2.
- `out_instr` and `out_pc` must hold stable while `out_valid`=1 and `out_ready`=0.
- `rst_n` asserted mid-operation clears the PC and queue immediately; no partial state survives.

## Configuration

- `IFETCH_PERF_EN`: when defined, two outputs are added:
  - `perf_fetched`: 32 bits, counts pop handshakes.
  - `perf_stalls`: 32 bits, counts cycles with `out_valid`=1 and `out_ready`=0.
  - Both counters reset to 0, saturate at all-ones, and are not cleared by a redirect.
- When undefined, the ports and the counter logic are absent. All other behaviour is identical.

## Structure

- Package `ifetch_pkg` holds:
  - `WORD_BYTES`=4.
  - The default `RESET_PC`.
  - Typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_queue` is a `QUEUE_DEPTH`-entry FIFO of `fetch_entry_t` with push, pop, synchronous flush, full and empty. The flush takes priority over push and pop.
- Top level holds the PC, limit compare, redirect logic and optional counters.

## Test plan

- Straight-line fetch: reset, then `out_ready`=1 for 20 cycles with `IMEM_WORDS`=17. Expect `out_pc` = 0, 4, …, 64 on consecutive cycles, each `out_instr` matching the memory model, then `done`=1.
- Backpressure: `out_ready`=0 for 5 cycles after the first valid. Expect the head to hold PC 0 stable, the queue to hold PCs 0 and 4, no PC advance past 8, and `perf_stalls`=5 with the macro defined.
- Redirect: `redirect_valid`=1 with `redirect_pc`=0x0C while the queue holds 0x10 and 0x14. Expect the next cycle `out_valid`=0, then `out_pc`=0x0C; 0x10 and 0x14 never appear before 0x0C.
- Misaligned redirect: `redirect_pc`=0x0E. Expect the next delivered `out_pc`=0x0C.
- Limit and restart: run to `done`=1, then redirect to 0x18. Expect `done`=0 the next cycle and `out_pc`=0x18 delivered.
- Mid-run reset: assert `rst_n`=0 while the queue is full. Expect `out_valid`=0 immediately, and after release `out_pc`=0 as the first output.
